// File: rtl/axi_tdd_pkg.sv
// Shared constants for the TDD controller blocks.
package axi_tdd_pkg;

  localparam int unsigned SYNC_COUNT_WIDTH_DEFAULT = 64;

endpackage

// File: rtl/sync_bits.sv
// Multi-stage flop synchronizer for bringing asynchronous levels into the clk domain.
module sync_bits #(
  parameter int unsigned NUM_OF_BITS = 1,
  parameter int unsigned STAGES      = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_OF_BITS-1:0] in_bits,
  output logic [NUM_OF_BITS-1:0] out_bits
);

  logic [NUM_OF_BITS-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= in_bits;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign out_bits = stage_q[STAGES-1];

endmodule

// File: rtl/tdd_sync_gen.sv
// TDD frame sync generator: merges internal periodic, external edge and software
// sync sources into a single registered one-cycle sync_out pulse.
module tdd_sync_gen
  import axi_tdd_pkg::*;
#(
  parameter bit          SYNC_INTERNAL     = 1'b1,
  parameter bit          SYNC_EXTERNAL     = 1'b1,
  parameter bit          SYNC_EXTERNAL_CDC = 1'b1,
  parameter int unsigned SYNC_COUNT_WIDTH  = SYNC_COUNT_WIDTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tdd_enable,
  input  logic                        sync_int_en,
  input  logic                        sync_ext_en,
  input  logic                        sync_soft_en,
  input  logic                        sync_in,
  input  logic                        sync_soft,
  input  logic [SYNC_COUNT_WIDTH-1:0] sync_period,
  output logic                        sync_out
);

  logic ext_event;
  logic soft_event;
  logic int_event;
  logic sync_event;
  logic sync_out_q;

  assign soft_event = tdd_enable & sync_soft_en & sync_soft;

  if (SYNC_EXTERNAL) begin : g_ext
    logic sync_cond;
    logic sync_hist_q;

    if (SYNC_EXTERNAL_CDC) begin : g_cdc
      sync_bits #(
        .NUM_OF_BITS (1),
        .STAGES      (2)
      ) i_sync_bits (
        .clk      (clk),
        .rst      (rst),
        .in_bits  (sync_in),
        .out_bits (sync_cond)
      );
    end else begin : g_no_cdc
      assign sync_cond = sync_in;
    end

    // History tracks even while disabled so enabling on a high level does not pulse.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_hist_q <= 1'b0;
      end else begin
        sync_hist_q <= sync_cond;
      end
    end

    assign ext_event = tdd_enable & sync_ext_en & sync_cond & ~sync_hist_q;
  end else begin : g_no_ext
    assign ext_event = 1'b0;
  end

  assign sync_event = ext_event | soft_event;

  if (SYNC_INTERNAL) begin : g_int
    logic [SYNC_COUNT_WIDTH-1:0] cnt_q;
    logic [SYNC_COUNT_WIDTH-1:0] cnt_d;
    logic                        run;
    logic                        wrap;

    assign run  = tdd_enable & sync_int_en & (sync_period != '0);
    // >= rather than == so a shrinking period wraps instead of counting through the range.
    assign wrap = run & (cnt_q >= sync_period - SYNC_COUNT_WIDTH'(1));

    always_comb begin
      cnt_d = cnt_q + SYNC_COUNT_WIDTH'(1);
      if (!run || wrap || sync_event) begin
        cnt_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign int_event = wrap;
  end else begin : g_no_int
    assign int_event = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_out_q <= 1'b0;
    end else begin
      sync_out_q <= sync_event | int_event;
    end
  end

  assign sync_out = sync_out_q;

endmodule

// File: tb/tb_tdd_sync_gen.sv
// Randomized and directed bench for tdd_sync_gen with a queue-based scoreboard,
// covering both the synchronized and the raw external sync path.
module tb_tdd_sync_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        tdd_enable;
  logic        sync_int_en;
  logic        sync_ext_en;
  logic        sync_soft_en;
  logic        sync_in;
  logic        sync_soft;
  logic [63:0] sync_period;
  logic        sync_out_cdc;
  logic        sync_out_raw;

  int checks = 0;
  int errors = 0;

  bit exp_cdc_q[$];
  bit exp_raw_q[$];

  // Reference state: cycles since the current frame started, last seen
  // conditioned level, and the two most recent sync_in samples for the CDC path.
  logic [63:0] m_elapsed [2];
  bit          m_prev    [2];
  bit          line_q[$];

  always #5 clk = ~clk;

  tdd_sync_gen dut_cdc (
    .clk          (clk),
    .rst          (rst),
    .tdd_enable   (tdd_enable),
    .sync_int_en  (sync_int_en),
    .sync_ext_en  (sync_ext_en),
    .sync_soft_en (sync_soft_en),
    .sync_in      (sync_in),
    .sync_soft    (sync_soft),
    .sync_period  (sync_period),
    .sync_out     (sync_out_cdc)
  );

  tdd_sync_gen #(
    .SYNC_EXTERNAL_CDC (1'b0)
  ) dut_raw (
    .clk          (clk),
    .rst          (rst),
    .tdd_enable   (tdd_enable),
    .sync_int_en  (sync_int_en),
    .sync_ext_en  (sync_ext_en),
    .sync_soft_en (sync_soft_en),
    .sync_in      (sync_in),
    .sync_soft    (sync_soft),
    .sync_period  (sync_period),
    .sync_out     (sync_out_raw)
  );

  // m = 1 models the 2-stage synchronized input, m = 0 the raw input.
  task automatic model_step(input int m, output bit exp);
    bit level, ext, sw_event, running, frame_done;
    if (rst) begin
      exp          = 1'b0;
      m_elapsed[m] = '0;
      m_prev[m]    = 1'b0;
      if (m == 1) line_q = '{1'b0, 1'b0};
    end else begin
      level      = (m == 1) ? line_q[0] : sync_in;
      ext        = sync_ext_en && level && !m_prev[m];
      sw_event   = tdd_enable && (ext || (sync_soft_en && sync_soft));
      running    = tdd_enable && sync_int_en && (sync_period != 0);
      frame_done = running && (m_elapsed[m] + 1 >= sync_period);
      exp        = sw_event || frame_done;
      m_elapsed[m] = (!running || exp) ? 64'd0 : m_elapsed[m] + 1;
      m_prev[m]    = level;
      if (m == 1) begin
        line_q.push_back(sync_in);
        void'(line_q.pop_front());
      end
    end
  endtask

  task automatic cycle();
    bit e_raw, e_cdc;
    model_step(0, e_raw);
    model_step(1, e_cdc);
    @(posedge clk);
    exp_raw_q.push_back(e_raw);
    exp_cdc_q.push_back(e_cdc);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_mode(input bit en, input bit ie, input bit ee, input bit se);
    tdd_enable   = en;
    sync_int_en  = ie;
    sync_ext_en  = ee;
    sync_soft_en = se;
  endtask

  always @(negedge clk) begin
    bit e;
    if (exp_raw_q.size() > 0) begin
      e = exp_raw_q.pop_front();
      checks++;
      if (sync_out_raw !== e) begin
        errors++;
        $display("FAIL sync_out_raw t=%0t got=%b want=%b", $time, sync_out_raw, e);
      end
    end
    if (exp_cdc_q.size() > 0) begin
      e = exp_cdc_q.pop_front();
      checks++;
      if (sync_out_cdc !== e) begin
        errors++;
        $display("FAIL sync_out_cdc t=%0t got=%b want=%b", $time, sync_out_cdc, e);
      end
    end
  end

  initial begin
    line_q = '{1'b0, 1'b0};
    rst = 1'b1;
    set_mode(1'b0, 1'b0, 1'b0, 1'b0);
    sync_in     = 1'b1;
    sync_soft   = 1'b0;
    sync_period = 64'd0;

    // sync_in held high through reset: exactly one pulse after release
    run(3);
    rst = 1'b0;
    set_mode(1'b1, 1'b0, 1'b1, 1'b0);
    run(6);
    sync_in = 1'b0;
    run(2);

    // Internal only, period 10
    set_mode(1'b1, 1'b1, 1'b0, 1'b0);
    sync_period = 64'd10;
    run(35);

    // External only, 5-cycle high level
    set_mode(1'b1, 1'b0, 1'b1, 1'b0);
    run(2);
    sync_in = 1'b1;
    run(5);
    sync_in = 1'b0;
    run(5);

    // Period 100 with an external event at count 40
    set_mode(1'b1, 1'b1, 1'b1, 1'b0);
    sync_period = 64'd100;
    run(40);
    sync_in = 1'b1;
    cycle();
    sync_in = 1'b0;
    run(150);

    // Software trigger coinciding with an internal wrap
    sync_period = 64'd10;
    sync_soft_en = 1'b1;
    run(12);
    for (int i = 0; i < 40 && m_elapsed[1] != sync_period - 1; i++) cycle();
    sync_soft = 1'b1;
    cycle();
    sync_soft = 1'b0;
    run(12);

    // Period shrink 1000 -> 5 at count 600
    set_mode(1'b1, 1'b0, 1'b0, 1'b0);
    sync_period = 64'd1000;
    cycle();
    sync_int_en = 1'b1;
    run(600);
    sync_period = 64'd5;
    run(20);

    // Reset at count 7 with period 10
    sync_period = 64'd10;
    sync_int_en = 1'b0;
    cycle();
    sync_int_en = 1'b1;
    run(7);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(25);

    // Enable rising while sync_in already high must not pulse
    set_mode(1'b0, 1'b0, 1'b1, 1'b0);
    sync_in = 1'b1;
    run(4);
    tdd_enable = 1'b1;
    run(4);
    sync_in = 1'b0;
    run(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        set_mode($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
        sync_period = 64'($urandom_range(0, 24));
      end
      if ($urandom_range(0, 5) == 0) sync_in = ~sync_in;
      sync_soft = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    sync_soft = 1'b0;
    run(2);

    @(negedge clk);
    #1;
    checks++;
    if (exp_raw_q.size() != 0 || exp_cdc_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d/%0d pending want=0", exp_raw_q.size(),
               exp_cdc_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tdd_sync_gen.md
TDD_SYNC_GEN -- requirements
Module: tdd_sync_gen

Interface
REQ-001 SHALL have parameter SYNC_INTERNAL, 1, includes the internal periodic sync counter when 1; when 0 the counter is absent and the source is treated as disabled.
REQ-002 SHALL have parameter SYNC_EXTERNAL, 1, includes the external sync path when 1; when 0 the path is absent and the source is treated as disabled.
REQ-003 SHALL have parameter SYNC_EXTERNAL_CDC, 1, places a 2-flop synchronizer on sync_in when 1.
REQ-004 SHALL have parameter SYNC_COUNT_WIDTH, 64, width of the sync period and counter.
REQ-005 SHALL have port clk  input  1  single clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port tdd_enable  input  1  global enable from the TDD control register.
REQ-008 SHALL have port sync_int_en  input  1  enables the internal counter source.
REQ-009 SHALL have port sync_ext_en  input  1  enables the external source.
REQ-010 SHALL have port sync_soft_en  input  1  enables the software source.
REQ-011 SHALL have port sync_in  input  1  external sync level, possibly asynchronous.
REQ-012 SHALL have port sync_soft  input  1  single-cycle software trigger pulse.
REQ-013 SHALL have port sync_period  input  SYNC_COUNT_WIDTH  internal sync period in clk cycles; 0 disables internal pulses.
REQ-014 SHALL have port sync_out  output  1  registered single-cycle sync pulse that starts a TDD frame.

Function
REQ-015 SHALL detect an external event as a rising edge of the conditioned sync_in (synchronizer output, or raw sync_in when CDC=0) against a one-cycle history register.
REQ-016 SHALL, when sync_in is first sampled high at edge k, assert sync_out after edge k+2 if CDC=1, or after edge k if CDC=0, given tdd_enable=1 and sync_ext_en=1.
REQ-017 SHALL assert sync_out after the edge at which sync_soft=1 is sampled, given tdd_enable=1 and sync_soft_en=1.
REQ-018 SHALL run the internal counter only while tdd_enable=1, sync_int_en=1 and sync_period!=0; otherwise the counter SHALL hold 0.
REQ-019 SHALL increment the counter by 1 per cycle and, when counter==sync_period-1, load 0 and assert sync_out on the next edge; the first pulse SHALL occur sync_period cycles after enabling.
REQ-020 SHALL compare counter and period at full SYNC_COUNT_WIDTH width with no truncation.
REQ-021 SHALL reload the counter to 0 on any enabled external or software event, so that internal pulses realign to the latest external or software sync.
REQ-022 SHALL, when sync_period changes so that counter>=sync_period-1, wrap and pulse at the next compare cycle and not count through 2^SYNC_COUNT_WIDTH.
REQ-023 SHALL OR all enabled sources into one pulse; simultaneous events SHALL produce exactly one single-cycle sync_out.
REQ-024 SHALL force sync_out=0 while tdd_enable=0, while the edge history continues tracking.
REQ-025 SHALL NOT pulse when tdd_enable rises while sync_in is already high.
REQ-026 SHALL never assert sync_out on two consecutive cycles except for distinct qualifying events on consecutive cycles.

Reset
REQ-027 SHALL, on rst=1 at a clk edge, clear the counter, synchronizer flops, history register and sync_out to 0.
REQ-028 SHALL treat sync_in held high through reset as a rising edge, producing exactly one pulse after rst deasserts if enabled.
REQ-029 SHALL let rst mid-count abandon the current period; the next internal pulse SHALL come sync_period cycles after rst deasserts.

Structure
REQ-030 SHALL place the default SYNC_COUNT_WIDTH constant (64) in shared package axi_tdd_pkg; no new typedefs are required.
REQ-031 SHALL instantiate the codebase synchronizer sub-module sync_bits (2 stages) for sync_in when SYNC_EXTERNAL_CDC=1.
REQ-032 SHALL use generate blocks to remove the counter or external path when SYNC_INTERNAL=0 or SYNC_EXTERNAL=0.

Verification
REQ-033 SHALL cover: period=10, int only -> sync_out pulses at cycles 10, 20, 30 after enable, each 1 cycle wide.
REQ-034 SHALL cover: CDC=1, ext only, sync_in high 5 cycles from edge k -> one pulse after edge k+2 only.
REQ-035 SHALL cover: period=100, ext event at count 40 -> counter reloads, next internal pulse 100 cycles after the ext pulse.
REQ-036 SHALL cover: sync_soft and counter wrap in the same cycle -> exactly one sync_out pulse.
REQ-037 SHALL cover: period changed 1000->5 at count 600 -> pulse on next cycle, then every 5 cycles.
REQ-038 SHALL cover: rst at count 7 with period=10 -> sync_out 0, next pulse 10 cycles after rst release; sync_in held high through rst -> one pulse.
